// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: iterative shift-add unsigned multiplier (MULTU) feeding a
// HI/LO register pair. A multiply takes WIDTH RUN cycles plus one DONE cycle.
// The product is held until the controller issues COMMIT, which copies it into HI/LO.
// MFHI/MFLO codes select HI or LO onto rd_data combinationally.
module mul_hilo_unit #(
    parameter int          WIDTH  = 32,
    parameter logic [5:0]  COMMIT = 6'b111111,
    parameter logic [5:0]  MFHI   = 6'd16,
    parameter logic [5:0]  MFLO   = 6'd18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [5:0]       ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    // Counter wide enough to hold WIDTH-1 and its increment without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic accept;
    logic last_step;

    // A start is accepted only from IDLE; while busy it is simply dropped.
    assign accept    = (state_q == IDLE) && start;
    assign last_step = (state_q == RUN) && (cnt_q == LAST);

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH edges, DONE for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Shift-add datapath: one multiplier bit consumed per RUN edge.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        valid_d  = valid_q;
        if (accept) begin
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
            prod_d   = '0;
            cnt_d    = '0;
            valid_d  = 1'b0;
        end else if (state_q == RUN) begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last_step) valid_d = 1'b1;
        end
    end

    // HI/LO commit: uses the registered product, so a COMMIT coinciding with a
    // new start in IDLE still writes the previous result.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if ((ctl == COMMIT) && valid_q) begin
            hi_d = prod_q[2*WIDTH-1:WIDTH];
            lo_d = prod_q[WIDTH-1:0];
        end
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            valid_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            valid_q  <= valid_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Move-from read port, zero when the control code is not a read.
    always_comb begin
        rd_data = '0;
        if (ctl == MFHI)      rd_data = hi_q;
        else if (ctl == MFLO) rd_data = lo_q;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Self-checking bench for mul_hilo_unit: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (product = a*b, available 33 edges after start).
module tb_mul_hilo_unit;

    localparam int W = 32;
    localparam logic [5:0] C_COMMIT = 6'b111111;
    localparam logic [5:0] C_MFHI   = 6'd16;
    localparam logic [5:0] C_MFLO   = 6'd18;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic [5:0]   ctl;
    logic         busy, done;
    logic [W-1:0] hi, lo, rd_data;

    int tests = 0;
    int fails = 0;

    mul_hilo_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .ctl(ctl), .busy(busy), .done(done), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // age: 0 = idle, otherwise number of edges since the accepted start (1..33).
    int           age = 0;
    logic [63:0]  m_pending = '0;
    logic [63:0]  m_prod = '0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            age = 0; m_valid = 1'b0; m_prod = '0; m_hi = '0; m_lo = '0;
        end else begin
            if (ctl == C_COMMIT && m_valid) begin
                m_hi = m_prod[63:32];
                m_lo = m_prod[31:0];
            end
            if (age == 0) begin
                if (start) begin
                    m_pending = {32'b0, op_a} * {32'b0, op_b};
                    m_valid   = 1'b0;
                    age       = 1;
                end
            end else if (age == 33) begin
                age = 0;
            end else begin
                age = age + 1;
                if (age == 33) begin
                    m_valid = 1'b1;
                    m_prod  = m_pending;
                end
            end
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [5:0] c);
        if (c == C_MFHI) return m_hi;
        if (c == C_MFLO) return m_lo;
        return '0;
    endfunction

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            tests += 5;
            if (busy !== (age != 0)) begin
                fails++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy, (age != 0));
            end
            if (done !== (age == 33)) begin
                fails++; $display("FAIL model_done t=%0t got %b want %b", $time, done, (age == 33));
            end
            if (hi !== m_hi) begin
                fails++; $display("FAIL model_hi t=%0t got %h want %h", $time, hi, m_hi);
            end
            if (lo !== m_lo) begin
                fails++; $display("FAIL model_lo t=%0t got %h want %h", $time, lo, m_lo);
            end
            if (rd_data !== exp_rd(ctl)) begin
                fails++; $display("FAIL model_rd t=%0t got %h want %h", $time, rd_data, exp_rd(ctl));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Issue a start (sampled at the next edge) and count edges until done is
    // visible, counting the sampling edge itself as edge 1.
    task automatic run_until_done(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL done_timeout got %0d edges want done", n);
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; ctl = 6'd0;
        tick(); tick();
        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        ctl = C_MFHI; #1;
        check("rst_rd", rd_data, 0);
        ctl = 6'd0;
        rst = 1'b0;
        chk_en = 1'b1;

        // 3*5, commit on the done cycle
        run_until_done(32'd3, 32'd5, n);
        check("lat_3x5", n, 33);
        ctl = C_COMMIT; tick(); ctl = 6'd0;
        check("hi_3x5", hi, 32'h0);
        check("lo_3x5", lo, 32'd15);
        check("idle_after_done", busy, 0);

        // all-ones operands
        run_until_done(32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        ctl = C_COMMIT; tick();
        ctl = C_COMMIT; tick();          // repeated commit is idempotent
        check("hi_ff", hi, 32'hFFFF_FFFE);
        check("lo_ff", lo, 32'h0000_0001);
        ctl = C_MFHI; #1;
        check("mfhi_ff", rd_data, 32'hFFFF_FFFE);
        ctl = 6'd0;

        // late commit from IDLE, 5 cycles after done
        run_until_done(32'h1234_5678, 32'h10, n);
        repeat (5) tick();
        check("hold_hi_before_commit", hi, 32'hFFFF_FFFE);
        ctl = C_COMMIT; tick();
        check("hi_late", hi, 32'h1);
        check("lo_late", lo, 32'h2345_6780);
        ctl = C_MFLO; #1;
        check("mflo_late", rd_data, 32'h2345_6780);
        ctl = 6'd0;

        // start while busy is ignored
        op_a = 32'd7; op_b = 32'd6; start = 1'b1; tick(); start = 1'b0;
        n = 1;
        repeat (9) begin tick(); n++; end
        op_a = 32'd9; op_b = 32'd9; start = 1'b1; tick(); n++; start = 1'b0;
        while (!done && n < 60) begin tick(); n++; end
        check("lat_ignore_restart", n, 33);
        ctl = C_COMMIT; tick(); ctl = 6'd0;
        check("hi_7x6", hi, 32'h0);
        check("lo_7x6", lo, 32'd42);

        // commit during RUN ignored, then reset mid-run
        op_a = 32'd100; op_b = 32'd200; start = 1'b1; tick(); start = 1'b0;
        ctl = C_COMMIT;
        repeat (19) tick();
        check("run_commit_hi", hi, 32'h0);
        check("run_commit_lo", lo, 32'd42);
        check("run_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        tick();                          // COMMIT still asserted with no valid product
        check("post_rst_commit_hi", hi, 0);
        check("post_rst_commit_lo", lo, 0);
        ctl = 6'd0;

        // simultaneous start+commit in IDLE commits the old product
        run_until_done(32'd11, 32'd13, n);
        tick();
        ctl = C_COMMIT; op_a = 32'd2; op_b = 32'd2; start = 1'b1; tick();
        start = 1'b0; ctl = 6'd0;
        check("start_commit_lo", lo, 32'd143);
        check("start_commit_busy", busy, 1);
        while (busy) tick();

        // randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 4000; i++) begin
            int sel;
            start = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0: op_a = 32'hFFFF_FFFF;
                1: op_a = 32'h0;
                default: op_a = $urandom;
            endcase
            sel = $urandom_range(0, 5);
            case (sel)
                0: op_b = 32'hFFFF_FFFF;
                1: op_b = 32'h1;
                default: op_b = $urandom;
            endcase
            sel = $urandom_range(0, 4);
            case (sel)
                0, 1: ctl = C_COMMIT;
                2: ctl = C_MFHI;
                3: ctl = C_MFLO;
                default: ctl = 6'($urandom);
            endcase
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; ctl = 6'd0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_hilo_unit.md
MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL provide parameter COMMIT, default 6'b111111, control code that writes the product into HI/LO.
REQ-003 SHALL provide parameter MFHI, default 6'd16, control code that selects HI onto rd_data.
REQ-004 SHALL provide parameter MFLO, default 6'd18, control code that selects LO onto rd_data.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request an unsigned multiply (MULTU issue).
REQ-008 SHALL have port op_a  input  WIDTH  multiplicand, sampled with start.
REQ-009 SHALL have port op_b  input  WIDTH  multiplier, sampled with start.
REQ-010 SHALL have port ctl  input  6  control code from the multiply controller.
REQ-011 SHALL have port busy  output  1  high while a multiply is in progress or completing.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the product is complete.
REQ-013 SHALL have port hi  output  WIDTH  HI register.
REQ-014 SHALL have port lo  output  WIDTH  LO register.
REQ-015 SHALL have port rd_data  output  WIDTH  MFHI/MFLO read data.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-017 IDLE with start=1 SHALL perform these actions at that edge:
- latch mcand <= zero-extended op_a (2*WIDTH bits);
- latch mplier <= op_b;
- set prod <= 0 and cnt <= 0;
- clear valid;
- go to RUN.
REQ-018 Each RUN edge SHALL perform these actions:
- if mplier[0]=1, prod <= prod + mcand (2*WIDTH bits, no overflow possible);
- mcand <= mcand << 1;
- mplier <= mplier >> 1;
- cnt <= cnt + 1.
REQ-019 RUN SHALL last exactly WIDTH edges; on the edge where cnt == WIDTH-1, go to DONE and set valid.
REQ-020 Latency SHALL be as follows for WIDTH=32, with start sampled at edge 0:
- RUN edges 1..32;
- done high for the cycle after edge 32;
- state returns to IDLE at edge 33.
REQ-021 DONE SHALL go unconditionally to IDLE after one cycle.
REQ-022 start SHALL be ignored while busy=1; no restart and no operand relatch.
REQ-023 prod and valid SHALL hold their values until the next accepted start or reset.
REQ-024 At an edge where ctl == COMMIT and valid=1, the block SHALL update hi <= prod[2*WIDTH-1:WIDTH] and lo <= prod[WIDTH-1:0].
REQ-025 ctl == COMMIT with valid=0 SHALL leave hi and lo unchanged.
REQ-026 COMMIT SHALL be honoured in the DONE state (same cycle as done) and in IDLE.
REQ-027 COMMIT SHALL be ignored during RUN, because valid=0 in RUN.
REQ-028 Repeated COMMIT cycles SHALL rewrite the same value into HI/LO (idempotent).
REQ-029 Simultaneous start and COMMIT in IDLE with valid=1 SHALL commit the old prod and start the new multiply in the same edge.
REQ-030 rd_data SHALL be combinational from the registers:
- hi when ctl == MFHI;
- lo when ctl == MFLO;
- 0 otherwise.
REQ-031 Codes other than COMMIT, MFHI and MFLO SHALL have no effect on state.

Reset
REQ-032 rst=1 at an edge SHALL take priority over all other inputs.
REQ-033 Reset SHALL force state=IDLE and set cnt, prod, mcand, mplier, valid, hi and lo to 0.
REQ-034 Consequently, after reset busy=0, done=0, hi=0, lo=0 and rd_data=0.
REQ-035 Reset during RUN or DONE SHALL abort the operation; a later COMMIT before a new product completes SHALL leave hi/lo at 0.

Verification
REQ-036 Bench SHALL drive op_a=3, op_b=5, start for one cycle, then COMMIT on the done cycle -> done exactly 33 cycles after start; hi=0, lo=15.
REQ-037 Bench SHALL drive op_a=op_b=0xFFFFFFFF, then COMMIT -> hi=0xFFFFFFFE, lo=0x00000001; ctl=MFHI gives rd_data=0xFFFFFFFE.
REQ-038 Bench SHALL drive op_a=0x12345678, op_b=0x10, COMMIT issued 5 cycles after done -> hi=0x00000001, lo=0x23456780; ctl=MFLO gives rd_data=0x23456780.
REQ-039 Bench SHALL start 7*6, then reassert start with op_a=9, op_b=9 at cycle 10 -> second start ignored; product 42 committed.
REQ-040 Bench SHALL assert COMMIT during RUN, then assert rst at RUN cycle 20, then assert COMMIT -> hi/lo unchanged by the first COMMIT; after reset hi=lo=0, busy=0, and the second COMMIT leaves hi=lo=0.
